// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 2:1 selection mux: drives SEL, issues grants,
// and keeps VALID low for a settle window after every SEL change.
module mux_sel_arbiter #(
    parameter int SETTLE   = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic       o_sel,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_valid,
    output logic [3:0] o_hold_cnt
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] HOLD_MAX    = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_GRANT0,
        ST_GRANT1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_sel;
    logic       w_sel_next;
    logic       r_last;
    logic       w_last_next;
    logic       r_gnt0;
    logic       w_gnt0_next;
    logic       r_gnt1;
    logic       w_gnt1_next;
    logic       r_valid;
    logic [3:0] r_hold;
    logic [3:0] w_hold_next;
    logic [3:0] r_settle;
    logic [3:0] w_settle_next;

    // Arbitration target: on a tie the side that did not own the mux last wins.
    logic w_has_tgt;
    logic w_tgt;
    logic w_req_sel;
    logic w_own;
    logic w_req_own;
    logic w_req_oth;

    assign w_has_tgt = i_req0 | i_req1;
    assign w_tgt     = (i_req0 & i_req1) ? ~r_last : i_req1;
    assign w_req_sel = r_sel ? i_req1 : i_req0;
    assign w_own     = (r_state == ST_GRANT1);
    assign w_req_own = w_own ? i_req1 : i_req0;
    assign w_req_oth = w_own ? i_req0 : i_req1;

    always_comb begin
        w_state_next  = r_state;
        w_sel_next    = r_sel;
        w_last_next   = r_last;
        w_hold_next   = r_hold;
        w_settle_next = r_settle;
        w_gnt0_next   = 1'b0;
        w_gnt1_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_next = 4'd0;
                if (w_has_tgt) begin
                    if (w_tgt == r_sel) begin
                        w_state_next = w_tgt ? ST_GRANT1 : ST_GRANT0;
                        w_last_next  = w_tgt;
                        w_hold_next  = 4'd1;
                        w_gnt0_next  = ~w_tgt;
                        w_gnt1_next  = w_tgt;
                    end else begin
                        w_sel_next    = w_tgt;
                        w_settle_next = SETTLE_LOAD;
                        w_state_next  = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                w_hold_next = 4'd0;
                if (r_settle == 4'd0) begin
                    // A requester that gave up while the mux settled loses the grant.
                    if (w_req_sel) begin
                        w_state_next = r_sel ? ST_GRANT1 : ST_GRANT0;
                        w_last_next  = r_sel;
                        w_hold_next  = 4'd1;
                        w_gnt0_next  = ~r_sel;
                        w_gnt1_next  = r_sel;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_settle_next = r_settle - 4'd1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!w_req_own || ((r_hold == HOLD_MAX) && w_req_oth)) begin
                    w_hold_next = 4'd0;
                    if (w_req_oth) begin
                        w_sel_next    = ~w_own;
                        w_settle_next = SETTLE_LOAD;
                        w_state_next  = ST_SWITCH;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_hold_next = (r_hold == HOLD_MAX) ? HOLD_MAX : r_hold + 4'd1;
                    w_gnt0_next = ~w_own;
                    w_gnt1_next = w_own;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid  <= 1'b0;
            r_hold   <= 4'd0;
            r_settle <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_sel    <= w_sel_next;
            r_last   <= w_last_next;
            r_gnt0   <= w_gnt0_next;
            r_gnt1   <= w_gnt1_next;
            r_valid  <= w_gnt0_next | w_gnt1_next;
            r_hold   <= w_hold_next;
            r_settle <= w_settle_next;
        end
    end

    assign o_sel      = r_sel;
    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_valid    = r_valid;
    assign o_hold_cnt = r_hold;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomised and directed stimulus for mux_sel_arbiter, compared every cycle
// against an owner/settle-time reference model.
module tb_mux_sel_arbiter;

    localparam int SETTLE   = 3;
    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic       sel;
    logic       gnt0;
    logic       gnt1;
    logic       valid;
    logic [3:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the mux, how long a settle still has to run.
    int m_owner;   // -1 none, else requester index
    int m_sel;
    int m_wait;    // remaining settle cycles, 0 when not switching
    int m_hold;
    int m_last;

    mux_sel_arbiter #(.SETTLE(SETTLE), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req0     (req0),
        .i_req1     (req1),
        .o_sel      (sel),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_valid    (valid),
        .o_hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int req_of(input int idx);
        return (idx == 0) ? int'(req0) : int'(req1);
    endfunction

    task automatic model_edge();
        int x;
        int o;
        int t;
        if (rst) begin
            m_owner = -1; m_sel = 0; m_wait = 0; m_hold = 0; m_last = 1;
        end else if (m_wait > 0) begin
            if (m_wait == 1) begin
                m_wait = 0;
                if (req_of(m_sel) != 0) begin
                    m_owner = m_sel; m_hold = 1; m_last = m_sel;
                end
            end else begin
                m_wait--;
            end
        end else if (m_owner >= 0) begin
            x = m_owner;
            o = 1 - x;
            if (req_of(x) == 0 || (m_hold == MAX_HOLD && req_of(o) != 0)) begin
                m_owner = -1;
                m_hold  = 0;
                if (req_of(o) != 0) begin
                    m_sel  = o;
                    m_wait = SETTLE;
                end
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end else begin
            t = -1;
            if (req0 && req1) t = 1 - m_last;
            else if (req0)    t = 0;
            else if (req1)    t = 1;
            if (t >= 0) begin
                if (t == m_sel) begin
                    m_owner = t; m_hold = 1; m_last = t;
                end else begin
                    m_sel = t; m_wait = SETTLE;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("sel",      int'(sel),      m_sel);
        check_eq("gnt0",     int'(gnt0),     int'(m_owner == 0));
        check_eq("gnt1",     int'(gnt1),     int'(m_owner == 1));
        check_eq("valid",    int'(valid),    int'(m_owner >= 0));
        check_eq("hold_cnt", int'(hold_cnt), m_hold);
        check_eq("gnt_excl", int'(gnt0 & gnt1), 0);
        $display("cyc rst=%0d req=%0d%0d sel=%0d gnt=%0d%0d valid=%0d hold=%0d",
                 rst, req0, req1, sel, gnt0, gnt1, valid, hold_cnt);
    endtask

    initial begin
        int cnt;
        m_owner = -1; m_sel = 0; m_wait = 0; m_hold = 0; m_last = 1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;

        // Reset held with both requesting, then requester 0 wins with no switch.
        repeat (2) step();
        rst = 1'b0;
        step();
        check_eq("first_gnt0", int'(gnt0), 1);

        // Both held: alternating preemption.
        repeat (45) step();

        // Saturation with no competitor.
        req1 = 1'b0;
        repeat (25) step();
        check_eq("sat_hold", int'(hold_cnt), MAX_HOLD);
        req0 = 1'b0;
        repeat (3) step();

        // Single switch from SEL=0.
        rst = 1'b1; step(); rst = 1'b0; step();
        req1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50 && !gnt1; i++) begin
            step();
            cnt++;
        end
        check_eq("sw_latency", cnt, SETTLE + 1);
        repeat (5) step();
        req1 = 1'b0;
        repeat (3) step();

        // Cancel in the second settle cycle.
        rst = 1'b1; step(); rst = 1'b0; step();
        req1 = 1'b1;
        step();
        step();
        req1 = 1'b0;
        repeat (6) step();
        check_eq("cancel_sel", int'(sel), 1);

        // Reset while requester 1 owns the mux.
        req1 = 1'b1;
        for (int i = 0; i < 50 && !gnt1; i++) step();
        check_eq("gnt1_reached", int'(gnt1), 1);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0; req1 = 1'b0;
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) req0 = ~req0;
            if ($urandom_range(5) == 0) req1 = ~req1;
            rst = ($urandom_range(199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
